tremolo_gain_stage: RTL and testbench



---
 rtl/tremolo_gain_stage.sv | 153 +++++++++++++++
 tb/tb_tremolo_gain_stage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/tremolo_gain_stage.sv
// rtl/tremolo_gain_stage.sv - tremolo amplitude modulation of a signed audio stream
//
// Scales each accepted sample by gain = 2^FRAC_BITS - ((depth * lfo) >> 4), with
// lfo clamped to LFO_MAX and depth clamped to 16, using an LSB-first shift-add
// multiplier (one gain bit per cycle). Fixed 13-cycle latency, one sample every
// 14 cycles.
//
// Ports:
//   CLK, RESET    clock, asynchronous active-high reset
//   sample_in     signed input sample, captured on accept
//   sample_valid  sample_in valid
//   sample_ready  block can accept (IDLE and not in reset)
//   lfo_val       unsigned LFO value, captured on accept
//   depth         modulation depth, captured on accept
//   sample_out    registered scaled sample, held between results
//   out_valid     one-cycle pulse while sample_out carries a fresh result
//   busy          operation in progress (LOAD, MUL, DONE)
module tremolo_gain_stage #(
    parameter int DATA_W    = 16,
    parameter int LFO_MAX   = 1000,
    parameter int FRAC_BITS = 10
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              sample_ready,
    input  logic [10:0]       lfo_val,
    input  logic [4:0]        depth,
    output logic [DATA_W-1:0] sample_out,
    output logic              out_valid,
    output logic              busy
);

    localparam int GAIN_W = FRAC_BITS + 1;
    localparam int ACC_W  = DATA_W + GAIN_W;
    localparam int CNT_W  = $clog2(GAIN_W);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(GAIN_W - 1);
    localparam logic [15:0]      GAIN_ONE  = 16'(1 << FRAC_BITS);
    localparam logic [10:0]      LFO_CEIL  = 11'(LFO_MAX);
    localparam logic [4:0]       DEPTH_MAX = 5'd16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                   state_q,      state_d;
    logic [DATA_W-1:0]        sample_q,     sample_d;
    logic [10:0]              lfo_q,        lfo_d;
    logic [4:0]               depth_q,      depth_d;
    logic [GAIN_W-1:0]        gain_q,       gain_d;
    logic [ACC_W-1:0]         acc_q,        acc_d;
    logic [CNT_W-1:0]         cnt_q,        cnt_d;
    logic [DATA_W-1:0]        sample_out_q, sample_out_d;
    logic                     out_valid_q,  out_valid_d;

    logic [10:0]              lfo_c;
    logic [4:0]               depth_c;
    logic [15:0]              dl_prod;
    logic [ACC_W-1:0]         sample_ext;

    assign sample_ready = (state_q == S_IDLE) && !RESET;
    assign busy         = (state_q != S_IDLE);
    assign sample_out   = sample_out_q;
    assign out_valid    = out_valid_q;

    // Sign-extended multiplicand; shifted left by the bit index each MUL cycle.
    assign sample_ext = {{(ACC_W - DATA_W){sample_q[DATA_W-1]}}, sample_q};

    always_comb begin
        state_d      = state_q;
        sample_d     = sample_q;
        lfo_d        = lfo_q;
        depth_d      = depth_q;
        gain_d       = gain_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        sample_out_d = sample_out_q;
        out_valid_d  = 1'b0;

        lfo_c   = (lfo_q > LFO_CEIL) ? LFO_CEIL : lfo_q;
        depth_c = (depth_q > DEPTH_MAX) ? DEPTH_MAX : depth_q;
        dl_prod = 16'(depth_c) * 16'(lfo_c);

        case (state_q)
            S_IDLE: begin
                if (sample_valid) begin
                    sample_d = sample_in;
                    lfo_d    = lfo_val;
                    depth_d  = depth;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                // depth*lfo <= 16000, so the >>4 term never exceeds 1000 and the gain stays >= 24.
                gain_d  = GAIN_W'(GAIN_ONE - (dl_prod >> 4));
                acc_d   = '0;
                cnt_d   = '0;
                state_d = S_MUL;
            end
            S_MUL: begin
                if (gain_q[cnt_q]) begin
                    acc_d = acc_q + (sample_ext << cnt_q);
                end
                if (cnt_q == CNT_LAST) begin
                    // Final partial product lands in the same edge that enters DONE,
                    // so sample_out is already valid during the DONE cycle.
                    cnt_d        = '0;
                    sample_out_d = acc_d[FRAC_BITS +: DATA_W];
                    out_valid_d  = 1'b1;
                    state_d      = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            sample_q     <= '0;
            lfo_q        <= '0;
            depth_q      <= '0;
            gain_q       <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            sample_out_q <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_q     <= sample_d;
            lfo_q        <= lfo_d;
            depth_q      <= depth_d;
            gain_q       <= gain_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            sample_out_q <= sample_out_d;
            out_valid_q  <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_tremolo_gain_stage.sv
// tb/tb_tremolo_gain_stage.sv - self-checking bench for tremolo_gain_stage
module tb_tremolo_gain_stage;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        sample_ready;
    logic [10:0] lfo_val;
    logic [4:0]  depth;
    logic [15:0] sample_out;
    logic        out_valid;
    logic        busy;

    always #5 CLK = ~CLK;

    tremolo_gain_stage #(
        .DATA_W(16),
        .LFO_MAX(1000),
        .FRAC_BITS(10)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .sample_in(sample_in),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .lfo_val(lfo_val),
        .depth(depth),
        .sample_out(sample_out),
        .out_valid(out_valid),
        .busy(busy)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] s;
        logic [10:0] l;
        logic [4:0]  d;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the clamped gain formula.
    function automatic logic [15:0] model(input logic [15:0] s, input logic [10:0] l, input logic [4:0] d);
        int sv, lc, dc, g, p, r;
        sv = int'($signed(s));
        lc = (int'(l) > 1000) ? 1000 : int'(l);
        dc = (int'(d) > 16) ? 16 : int'(d);
        g  = 1024 - ((dc * lc) / 16);
        p  = sv * g;
        r  = p >>> 10;
        return r[15:0];
    endfunction

    task automatic run_one(input string name, input logic [15:0] s, input logic [10:0] l,
                           input logic [4:0] d, input logic [15:0] exp);
        int w;
        int lat;
        w = 0;
        while (!sample_ready && w < 40) begin
            @(negedge CLK);
            w++;
        end
        chk({name, " ready"}, 32'(sample_ready), 32'd1);
        sample_in    = s;
        lfo_val      = l;
        depth        = d;
        sample_valid = 1'b1;
        @(posedge CLK);
        lat = 0;
        while (lat < 40) begin
            @(negedge CLK);
            lat++;
            if (lat == 1) begin
                sample_valid = 1'b0;
                sample_in    = 16'($urandom);
                lfo_val      = 11'($urandom);
                depth        = 5'($urandom);
                chk({name, " busy"}, 32'(busy), 32'd1);
                chk({name, " ready_low"}, 32'(sample_ready), 32'd0);
            end
            if (out_valid) break;
        end
        chk({name, " latency"}, 32'(lat), 32'd13);
        chk({name, " result"}, 32'(sample_out), 32'(exp));
        @(negedge CLK);
        chk({name, " pulse_end"}, 32'(out_valid), 32'd0);
        chk({name, " hold"}, 32'(sample_out), 32'(exp));
    endtask

    initial begin
        logic [15:0] q[$];
        logic [15:0] rs;
        logic [10:0] rl;
        logic [4:0]  rd;
        int last_acc, nacc, nval, pulses;

        tbl[0] = '{16'h4000, 11'd500,  5'd0,  16'h4000};
        tbl[1] = '{16'h0400, 11'd1000, 5'd16, 16'h0018};
        tbl[2] = '{16'hFC18, 11'd500,  5'd8,  16'hFD0C};
        tbl[3] = '{16'h7FFF, 11'd2047, 5'd31, 16'h02FF};
        tbl[4] = '{16'h8000, 11'd2047, 5'd31, 16'hFD00};
        tbl[5] = '{16'hFFFF, 11'd1000, 5'd16, 16'hFFFF};
        tbl[6] = '{16'h7FFF, 11'd0,    5'd16, 16'h7FFF};
        tbl[7] = '{16'h0000, 11'd123,  5'd9,  16'h0000};

        RESET        = 1'b1;
        sample_valid = 1'b0;
        sample_in    = 16'h1234;
        lfo_val      = 11'd0;
        depth        = 5'd0;
        repeat (3) @(negedge CLK);
        chk("reset sample_out", 32'(sample_out), 32'd0);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset ready", 32'(sample_ready), 32'd0);
        RESET = 1'b0;
        #1;
        chk("post-reset ready", 32'(sample_ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            run_one($sformatf("vec%0d", i), tbl[i].s, tbl[i].l, tbl[i].d, tbl[i].exp);
        end

        for (int i = 0; i < 20; i++) begin
            rs = 16'($urandom);
            rl = 11'($urandom);
            rd = 5'($urandom_range(0, 31));
            run_one($sformatf("rand%0d", i), rs, rl, rd, model(rs, rl, rd));
        end

        // Back-to-back with inputs churning every cycle.
        last_acc = -1;
        nacc     = 0;
        nval     = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge CLK);
            if (out_valid) begin
                nval++;
                if (q.size() == 0) chk("b2b spurious pulse", 32'd1, 32'd0);
                else chk("b2b result", 32'(sample_out), 32'(q.pop_front()));
            end
            if (c < 85) begin
                sample_in    = 16'($urandom);
                lfo_val      = 11'($urandom);
                depth        = 5'($urandom);
                sample_valid = 1'b1;
                if (sample_ready) begin
                    q.push_back(model(sample_in, lfo_val, depth));
                    nacc++;
                    if (last_acc >= 0) chk("b2b spacing", 32'(c - last_acc), 32'd14);
                    last_acc = c;
                end
            end else begin
                sample_valid = 1'b0;
            end
        end
        chk("b2b accepts", 32'(nacc), 32'd7);
        chk("b2b pulses", 32'(nval), 32'(nacc));
        chk("b2b drained", 32'(q.size()), 32'd0);

        // Reset six cycles into an operation.
        run_one("pre-reset", 16'h3000, 11'd200, 5'd4, model(16'h3000, 11'd200, 5'd4));
        sample_in    = 16'h5555;
        lfo_val      = 11'd700;
        depth        = 5'd12;
        sample_valid = 1'b1;
        @(posedge CLK);
        repeat (6) @(posedge CLK);
        @(negedge CLK);
        sample_valid = 1'b0;
        RESET        = 1'b1;
        #1;
        chk("abort sample_out", 32'(sample_out), 32'd0);
        chk("abort out_valid", 32'(out_valid), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort ready", 32'(sample_ready), 32'd0);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk("release ready", 32'(sample_ready), 32'd1);
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (out_valid) pulses++;
        end
        chk("abort no pulse", 32'(pulses), 32'd0);
        chk("abort out stays 0", 32'(sample_out), 32'd0);
        run_one("after-reset", 16'hC000, 11'd800, 5'd10, model(16'hC000, 11'd800, 5'd10));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
